// File: rtl/load_store_unit_pkg.sv
// Shared types for the memory stage: request/writeback structs, FSM state and
// the funct3 access-size encodings.
package load_store_unit_pkg;

    localparam int unsigned cXLEN = 32;

    typedef enum logic {
        eLsuIdle,
        eLsuBusy
    } tLsuState;

    localparam logic [2:0] cLsByte  = 3'b000;
    localparam logic [2:0] cLsHalf  = 3'b001;
    localparam logic [2:0] cLsWord  = 3'b010;
    localparam logic [2:0] cLsByteU = 3'b100;
    localparam logic [2:0] cLsHalfU = 3'b101;

    typedef struct packed {
        logic             read;
        logic             write;
        logic [cXLEN-1:0] addr;
        logic [cXLEN-1:0] data;
        logic [2:0]       opType;
        logic [4:0]       rdAddr;
    } tMemOp;

    typedef struct packed {
        logic             dv;
        logic [4:0]       rdAddr;
        logic [cXLEN-1:0] data;
    } tRegOp;

    typedef struct packed {
        logic             req;
        logic             we;
        logic [cXLEN-1:0] addr;
        logic [cXLEN-1:0] wdata;
        logic [3:0]       be;
    } tBusReq;

    function automatic logic fnIsHalf(input logic [2:0] opType);
        return (opType == cLsHalf) || (opType == cLsHalfU);
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane alignment for the memory stage: store lane replication and byte
// enables, load extract/extend, and request legality checks.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic             is_store_i,
    input  logic [2:0]       op_type_i,
    input  logic [1:0]       addr_lo_i,
    input  logic [cXLEN-1:0] st_data_i,
    output logic             legal_o,
    output logic             misalign_o,
    output logic [cXLEN-1:0] st_wdata_o,
    output logic [3:0]       be_o,
    input  logic [2:0]       ld_op_type_i,
    input  logic [1:0]       ld_offs_i,
    input  logic [cXLEN-1:0] rdata_i,
    output logic [cXLEN-1:0] ld_data_o
);

    logic [cXLEN-1:0] shifted;

    always_comb begin
        legal_o = 1'b0;
        case (op_type_i)
            cLsByte, cLsHalf, cLsWord: legal_o = 1'b1;
            cLsByteU, cLsHalfU:        legal_o = !is_store_i;
            default:                   legal_o = 1'b0;
        endcase
        misalign_o = (fnIsHalf(op_type_i) && addr_lo_i[0]) ||
                     ((op_type_i == cLsWord) && (addr_lo_i != 2'b00));
    end

    always_comb begin
        st_wdata_o = st_data_i;
        be_o       = '1;
        if (is_store_i) begin
            case (op_type_i)
                cLsByte: begin
                    st_wdata_o = {4{st_data_i[7:0]}};
                    be_o       = 4'b0001 << addr_lo_i;
                end
                cLsHalf: begin
                    st_wdata_o = {2{st_data_i[15:0]}};
                    be_o       = 4'b0011 << addr_lo_i;
                end
                default: begin
                    st_wdata_o = st_data_i;
                    be_o       = '1;
                end
            endcase
        end
    end

    always_comb begin
        shifted   = rdata_i >> {ld_offs_i, 3'b000};
        ld_data_o = shifted;
        case (ld_op_type_i)
            cLsByte:  ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
            cLsHalf:  ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
            cLsByteU: ld_data_o = {24'h0, shifted[7:0]};
            cLsHalfU: ld_data_o = {16'h0, shifted[15:0]};
            default:  ld_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: single-outstanding data-bus transaction with byte-lane
// alignment, ack timeout, and load writeback to the register file.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned pXLEN       = cXLEN,
    parameter int unsigned pAckTimeout = 255
) (
    input  logic             iClk,
    input  logic             iRstN,
    input  tMemOp            iMemOp,
    input  logic             iMemOpDv,
    output logic             oStall,
    output logic             oBusReq,
    output logic             oBusWe,
    output logic [pXLEN-1:0] oBusAddr,
    output logic [pXLEN-1:0] oBusWData,
    output logic [3:0]       oBusBe,
    input  logic             iBusAck,
    input  logic [pXLEN-1:0] iBusRData,
    output tRegOp            oRegOp,
    output logic             oExcMisalign,
    output logic             oExcBusTo
);

    localparam int unsigned     cCntW    = (pAckTimeout > 1) ? $clog2(pAckTimeout) : 1;
    localparam logic [cCntW-1:0] cCntLast = cCntW'(pAckTimeout - 1);

    tLsuState          state_q, state_d;
    logic [cCntW-1:0]  cnt_q, cnt_d;
    tBusReq            bus_q, bus_d;
    logic [2:0]        ldOp_q, ldOp_d;
    logic [1:0]        ldOffs_q, ldOffs_d;
    logic [4:0]        rd_q, rd_d;
    tRegOp             regOp_q, regOp_d;
    logic              excMis_q, excMis_d;
    logic              excTo_q, excTo_d;

    logic              legal, misalign;
    logic [cXLEN-1:0]  stWData, ldData;
    logic [3:0]        be;
    logic              reqOne, accept, reject, ackTimeout;

    lsu_align u_align (
        .is_store_i   (iMemOp.write),
        .op_type_i    (iMemOp.opType),
        .addr_lo_i    (iMemOp.addr[1:0]),
        .st_data_i    (iMemOp.data),
        .legal_o      (legal),
        .misalign_o   (misalign),
        .st_wdata_o   (stWData),
        .be_o         (be),
        .ld_op_type_i (ldOp_q),
        .ld_offs_i    (ldOffs_q),
        .rdata_i      (iBusRData),
        .ld_data_o    (ldData)
    );

    assign reqOne     = iMemOp.read ^ iMemOp.write;
    assign accept     = (state_q == eLsuIdle) && iMemOpDv && reqOne && legal && !misalign;
    assign reject     = (state_q == eLsuIdle) && iMemOpDv && reqOne && !(legal && !misalign);
    // Ack in the final counting cycle takes priority over the timeout.
    assign ackTimeout = (pAckTimeout != 0) && !iBusAck && (cnt_q == cCntLast);

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= eLsuIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            eLsuIdle: if (accept) state_d = eLsuBusy;
            eLsuBusy: if (iBusAck || ackTimeout) state_d = eLsuIdle;
            default:  state_d = eLsuIdle;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        bus_d    = bus_q;
        ldOp_d   = ldOp_q;
        ldOffs_d = ldOffs_q;
        rd_d     = rd_q;
        regOp_d  = '0;
        excMis_d = 1'b0;
        excTo_d  = 1'b0;
        case (state_q)
            eLsuIdle: begin
                if (accept) begin
                    cnt_d       = '0;
                    bus_d.req   = 1'b1;
                    bus_d.we    = iMemOp.write;
                    bus_d.addr  = {iMemOp.addr[cXLEN-1:2], 2'b00};
                    bus_d.wdata = iMemOp.write ? stWData : '0;
                    bus_d.be    = be;
                    ldOp_d      = iMemOp.opType;
                    ldOffs_d    = iMemOp.addr[1:0];
                    rd_d        = iMemOp.rdAddr;
                end
                excMis_d = reject;
            end
            eLsuBusy: begin
                if (iBusAck) begin
                    bus_d.req = 1'b0;
                    if (!bus_q.we) begin
                        regOp_d.dv     = (rd_q != 5'd0);
                        regOp_d.rdAddr = rd_q;
                        regOp_d.data   = ldData;
                    end
                end else if (ackTimeout) begin
                    bus_d.req = 1'b0;
                    excTo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: bus_d.req = 1'b0;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            cnt_q    <= '0;
            bus_q    <= '0;
            ldOp_q   <= '0;
            ldOffs_q <= '0;
            rd_q     <= '0;
            regOp_q  <= '0;
            excMis_q <= 1'b0;
            excTo_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            bus_q    <= bus_d;
            ldOp_q   <= ldOp_d;
            ldOffs_q <= ldOffs_d;
            rd_q     <= rd_d;
            regOp_q  <= regOp_d;
            excMis_q <= excMis_d;
            excTo_q  <= excTo_d;
        end
    end

    assign oStall       = (state_q == eLsuBusy);
    assign oBusReq      = bus_q.req;
    assign oBusWe       = bus_q.we;
    assign oBusAddr     = bus_q.addr;
    assign oBusWData    = bus_q.wdata;
    assign oBusBe       = bus_q.be;
    assign oRegOp       = regOp_q;
    assign oExcMisalign = excMis_q;
    assign oExcBusTo    = excTo_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus randomized requests checked
// against a transaction-level model of alignment, legality and timeout rules.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        iClk = 1'b0;
    logic        iRstN;
    tMemOp       iMemOp;
    logic        iMemOpDv;
    logic        oStall, oBusReq, oBusWe;
    logic [31:0] oBusAddr, oBusWData;
    logic [3:0]  oBusBe;
    logic        iBusAck;
    logic [31:0] iBusRData;
    tRegOp       oRegOp;
    logic        oExcMisalign, oExcBusTo;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 iClk = ~iClk;

    load_store_unit #(.pXLEN(32), .pAckTimeout(4)) dut (
        .iClk(iClk), .iRstN(iRstN), .iMemOp(iMemOp), .iMemOpDv(iMemOpDv),
        .oStall(oStall), .oBusReq(oBusReq), .oBusWe(oBusWe), .oBusAddr(oBusAddr),
        .oBusWData(oBusWData), .oBusBe(oBusBe), .iBusAck(iBusAck),
        .iBusRData(iBusRData), .oRegOp(oRegOp), .oExcMisalign(oExcMisalign),
        .oExcBusTo(oExcBusTo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [31:0] sh, res;
        sh = rdata >> (8 * (addr % 4));
        case (op)
            3'd0: begin res = sh & 32'hFF;   if (res[7])  res = res | 32'hFFFF_FF00; end
            3'd1: begin res = sh & 32'hFFFF; if (res[15]) res = res | 32'hFFFF_0000; end
            3'd4: res = sh & 32'hFF;
            3'd5: res = sh & 32'hFFFF;
            default: res = rdata;
        endcase
        return res;
    endfunction

    // dly: cycle after acceptance on which ack is driven; above 4 means never.
    task automatic do_op(input logic r, input logic w, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd, input logic dv, input int unsigned dly,
                         input logic [31:0] rdata);
        tMemOp       m, junk;
        tRegOp       e;
        logic        legal, mis, acked;
        int unsigned size;
        logic [31:0] exp_wd;
        logic [3:0]  exp_be;
        m.read = r; m.write = w; m.addr = addr; m.data = data; m.opType = op; m.rdAddr = rd;
        iMemOp = m;
        iMemOpDv = dv;
        tick();
        iMemOpDv = 1'b0;
        check("dv_pulse_width", 64'(oRegOp.dv), 64'(0));
        check("busto_pulse_width", 64'(oExcBusTo), 64'(0));
        if (!dv || (r == w)) begin
            check("noop_stall", 64'(oStall), 64'(0));
            check("noop_busreq", 64'(oBusReq), 64'(0));
            check("noop_misalign", 64'(oExcMisalign), 64'(0));
            return;
        end
        legal = w ? (op inside {3'd0, 3'd1, 3'd2}) : (op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
        mis   = (addr % size) != 0;
        if (!legal || mis) begin
            check("reject_exc", 64'(oExcMisalign), 64'(1));
            check("reject_stall", 64'(oStall), 64'(0));
            check("reject_busreq", 64'(oBusReq), 64'(0));
            tick();
            check("reject_exc_pulse", 64'(oExcMisalign), 64'(0));
            check("reject_busreq2", 64'(oBusReq), 64'(0));
            check("reject_stall2", 64'(oStall), 64'(0));
            return;
        end
        exp_be = 4'hF;
        exp_wd = data;
        if (w && size == 1) begin exp_be = 4'b0001 << (addr % 4); exp_wd = data[7:0] * 32'h0101_0101; end
        if (w && size == 2) begin exp_be = 4'b0011 << (addr % 4); exp_wd = data[15:0] * 32'h0001_0001; end
        check("accept_no_exc", 64'(oExcMisalign), 64'(0));
        acked = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check("busy_busreq", 64'(oBusReq), 64'(1));
            check("busy_stall", 64'(oStall), 64'(1));
            check("bus_addr", 64'(oBusAddr), 64'(addr & 32'hFFFF_FFFC));
            check("bus_we", 64'(oBusWe), 64'(w));
            check("bus_be", 64'(oBusBe), 64'(exp_be));
            if (w) check("bus_wdata", 64'(oBusWData), 64'(exp_wd));
            junk.read = 1'b1; junk.write = 1'b0; junk.addr = $urandom & 32'hFFFF_FFFC;
            junk.data = $urandom; junk.opType = 3'd2; junk.rdAddr = 5'd7;
            iMemOp = junk;
            iMemOpDv = 1'b1;
            if (k == dly) begin
                iBusAck = 1'b1; iBusRData = rdata; acked = 1'b1;
            end else begin
                iBusRData = $urandom;
            end
            tick();
            iBusAck = 1'b0;
            iMemOpDv = 1'b0;
            if (acked) break;
        end
        check("done_busreq", 64'(oBusReq), 64'(0));
        check("done_stall", 64'(oStall), 64'(0));
        check("done_misalign", 64'(oExcMisalign), 64'(0));
        if (acked) begin
            check("ack_no_timeout", 64'(oExcBusTo), 64'(0));
            if (r && rd != 5'd0) begin
                e.dv = 1'b1; e.rdAddr = rd; e.data = model_load(op, addr, rdata);
                check("load_writeback", 64'(oRegOp), 64'(e));
            end else begin
                check("no_writeback", 64'(oRegOp.dv), 64'(0));
            end
        end else begin
            check("timeout_exc", 64'(oExcBusTo), 64'(1));
            check("timeout_no_wb", 64'(oRegOp.dv), 64'(0));
        end
    endtask

    initial begin
        logic        r, w, dv;
        logic [2:0]  op;
        int unsigned sel;
        iRstN = 1'b0; iMemOp = '0; iMemOpDv = 1'b0; iBusAck = 1'b0; iBusRData = '0;
        #3;
        check("rst_stall", 64'(oStall), 64'(0));
        check("rst_busreq", 64'(oBusReq), 64'(0));
        check("rst_bus_fields", {oBusWe, oBusBe, oBusAddr}, 64'(0));
        check("rst_wdata", 64'(oBusWData), 64'(0));
        check("rst_regop", 64'(oRegOp), 64'(0));
        check("rst_exc", {oExcMisalign, oExcBusTo}, 64'(0));
        tick();
        iBusAck = 1'b1;
        iRstN = 1'b1;
        tick();
        iBusAck = 1'b0;
        check("idle_ack_ignored", {oStall, oBusReq, oRegOp.dv}, 64'(0));

        do_op(1, 0, 3'd2, 32'h100, 32'h0, 5'd5, 1, 3, 32'hDEADBEEF);
        do_op(1, 0, 3'd0, 32'h103, 32'h0, 5'd6, 1, 1, 32'h80FFFFFF);
        do_op(1, 0, 3'd4, 32'h103, 32'h0, 5'd7, 1, 2, 32'h80FFFFFF);
        do_op(1, 0, 3'd5, 32'h102, 32'h0, 5'd8, 1, 1, 32'hBEEF1234);
        do_op(0, 1, 3'd0, 32'h201, 32'hA5, 5'd9, 1, 1, 32'h0);
        do_op(0, 1, 3'd1, 32'h202, 32'h1234CAFE, 5'd9, 1, 2, 32'h0);
        do_op(1, 0, 3'd2, 32'h102, 32'h0, 5'd1, 1, 1, 32'h0);
        do_op(0, 1, 3'd1, 32'h201, 32'h0, 5'd1, 1, 1, 32'h0);
        do_op(1, 0, 3'd3, 32'h100, 32'h0, 5'd1, 1, 1, 32'h0);
        do_op(1, 0, 3'd2, 32'h300, 32'h0, 5'd2, 1, 5, 32'h12345678);
        do_op(1, 0, 3'd2, 32'h300, 32'h0, 5'd2, 1, 4, 32'h12345678);
        do_op(1, 0, 3'd2, 32'h304, 32'h0, 5'd0, 1, 1, 32'hFFFFFFFF);
        do_op(1, 1, 3'd2, 32'h300, 32'h0, 5'd3, 1, 1, 32'h0);

        iMemOp.read = 1'b1; iMemOp.write = 1'b0; iMemOp.addr = 32'h400;
        iMemOp.opType = 3'd2; iMemOp.rdAddr = 5'd4; iMemOpDv = 1'b1;
        tick();
        iMemOpDv = 1'b0;
        check("pre_rst_busreq", 64'(oBusReq), 64'(1));
        tick();
        #2;
        iRstN = 1'b0;
        #1;
        check("async_rst_busreq", 64'(oBusReq), 64'(0));
        check("async_rst_stall", 64'(oStall), 64'(0));
        iBusAck = 1'b1; iBusRData = 32'hAAAA5555;
        tick();
        iRstN = 1'b1;
        tick();
        iBusAck = 1'b0;
        check("late_ack_ignored", {oRegOp.dv, oBusReq, oStall}, 64'(0));
        do_op(1, 0, 3'd2, 32'h400, 32'h0, 5'd4, 1, 2, 32'h0BADF00D);

        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            r   = (sel < 4) || (sel == 8);
            w   = ((sel >= 4) && (sel < 8)) || (sel == 8);
            op  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) op = w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2));
            dv  = ($urandom_range(0, 9) != 0);
            do_op(r, w, op, $urandom, $urandom, 5'($urandom), dv, $urandom_range(1, 5), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, limit 200000 reached");
        $fatal(1, "watchdog");
    end

endmodule
